// File: rtl/fpnew_pkg.sv
// rtl/fpnew_pkg.sv - floating-point format enumeration and width helpers
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32,
        FP64,
        FP16,
        FP8,
        FP16ALT
    } fp_format_e;

    function automatic int unsigned exp_bits(input fp_format_e fmt);
        case (fmt)
            FP32:    return 8;
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned fp_width(input fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP8:     return 8;
            default: return 16;
        endcase
    endfunction

endpackage

// File: rtl/sfm_fp_vect_max_acc.sv
// rtl/sfm_fp_vect_max_acc.sv - streaming row maximum over masked floating-point vector beats
//
// Purpose: reduces each row of vector beats to its maximum element. Stage 1 registers the
// lane-max of an accepted beat; stage 2 folds it into the row accumulator. The result is
// presented on max_o/valid_o until the downstream handshake.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous flush to idle (wins over everything)
//   enable_i             global stall when low
//   valid_i/ready_o      input beat handshake; last_i marks the final beat of a row
//   strb_i, vect_i       per-lane enables and lane operands
//   max_o/valid_o        row maximum and its valid; ready_i is the downstream accept
//
// Optional feature: define SFM_MAX_NAN_PROPAGATE_EN to make any unmasked NaN lane turn the
// row result into the canonical quiet NaN; otherwise NaN lanes are ignored like masked lanes.
module sfm_fp_vect_max_acc #(
    parameter fpnew_pkg::fp_format_e FPFORMAT   = fpnew_pkg::FP16ALT,
    parameter int unsigned           VECT_WIDTH = 16,
    localparam int unsigned          WIDTH      = fpnew_pkg::fp_width(FPFORMAT)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             clear_i,
    input  logic                             enable_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic                             last_i,
    input  logic [VECT_WIDTH-1:0]            strb_i,
    input  logic [VECT_WIDTH-1:0][WIDTH-1:0] vect_i,
    output logic [WIDTH-1:0]                 max_o,
    output logic                             valid_o,
    input  logic                             ready_i
);

    localparam int unsigned EXP_BITS = fpnew_pkg::exp_bits(FPFORMAT);
    localparam int unsigned MAN_BITS = WIDTH - 1 - EXP_BITS;

    localparam logic [WIDTH-1:0] NEG_INF = {1'b1, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
    localparam logic [WIDTH-1:0] QNAN    = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};

    function automatic logic is_nan(input logic [WIDTH-1:0] x);
        return (&x[WIDTH-2:MAN_BITS]) && (|x[MAN_BITS-1:0]);
    endfunction

    // Maps a non-NaN encoding onto an unsigned key whose order is IEEE total order:
    // negatives are bit-inverted, positives get the sign bit set, so -0 sits just below +0.
    function automatic logic [WIDTH-1:0] order_key(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? ~x : {1'b1, x[WIDTH-2:0]};
    endfunction

    function automatic logic greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return order_key(a) > order_key(b);
    endfunction

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_e;

    state_e           state_q, state_d;
    logic             accept;
    logic             handshake;
    logic [WIDTH-1:0] lane_max;
    logic             lane_nan;
    logic             s1_valid_q;
    logic             s1_last_q;
    logic [WIDTH-1:0] s1_max_q;
    logic             s1_nan_q;
    logic [WIDTH-1:0] acc_q;
    logic             acc_nan_q;

    assign ready_o   = enable_i & ((state_q == IDLE) | (state_q == ACCUM));
    assign accept    = valid_i & ready_o;
    assign valid_o   = (state_q == DONE);
    assign handshake = valid_o & ready_i & enable_i;
    assign max_o     = acc_nan_q ? QNAN : acc_q;

    // Lane reduction; masked and NaN lanes never win, so an empty beat yields -inf.
    always_comb begin
        lane_max = NEG_INF;
        lane_nan = 1'b0;
        for (int i = 0; i < int'(VECT_WIDTH); i++) begin
            if (strb_i[i] && !is_nan(vect_i[i]) && greater(vect_i[i], lane_max)) begin
                lane_max = vect_i[i];
            end
`ifdef SFM_MAX_NAN_PROPAGATE_EN
            if (strb_i[i] && is_nan(vect_i[i])) begin
                lane_nan = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = last_i ? DRAIN : ACCUM;
            ACCUM:   if (accept && last_i) state_d = DRAIN;
            DRAIN:   if (s1_valid_q && s1_last_q) state_d = DONE;
            DONE:    if (handshake) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else if (clear_i) begin
            state_q <= IDLE;
        end else if (enable_i) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_max_q   <= '0;
            s1_nan_q   <= 1'b0;
            acc_q      <= NEG_INF;
            acc_nan_q  <= 1'b0;
        end else if (clear_i) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_nan_q   <= 1'b0;
            acc_q      <= NEG_INF;
            acc_nan_q  <= 1'b0;
        end else if (enable_i) begin
            s1_valid_q <= accept;
            s1_last_q  <= last_i;
            s1_max_q   <= lane_max;
            s1_nan_q   <= lane_nan;
            // Stage 1 is never valid in DONE, so the reload cannot collide with an update.
            if (handshake) begin
                acc_q     <= NEG_INF;
                acc_nan_q <= 1'b0;
            end else if (s1_valid_q) begin
                if (greater(s1_max_q, acc_q)) begin
                    acc_q <= s1_max_q;
                end
                acc_nan_q <= acc_nan_q | s1_nan_q;
            end
        end
    end

endmodule

// File: tb/tb_sfm_fp_vect_max_acc.sv
// tb/tb_sfm_fp_vect_max_acc.sv - scoreboard bench for sfm_fp_vect_max_acc
module tb_sfm_fp_vect_max_acc;

    localparam int VW = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear_i;
    logic              enable_i;
    logic              valid_i;
    logic              ready_o;
    logic              last_i;
    logic [VW-1:0]     strb_i;
    logic [VW-1:0][15:0] vect_i;
    logic [15:0]       max_o;
    logic              valid_o;
    logic              ready_i;

    sfm_fp_vect_max_acc dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clear_i  (clear_i),
        .enable_i (enable_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .last_i   (last_i),
        .strb_i   (strb_i),
        .vect_i   (vect_i),
        .max_o    (max_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    bit          rnd = 0;
    logic [15:0] exp_q[$];
    logic [15:0] row_max;
    bit          row_nan;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Real value of a bfloat16 encoding; infinities map to huge finite values.
    function automatic real to_real(input logic [15:0] x);
        int  e = int'(x[14:7]);
        real m;
        if (e == 0)        m = real'(x[6:0]) / 128.0 * (2.0 ** (-126));
        else if (e == 255) m = 1.0e300;
        else               m = (1.0 + real'(x[6:0]) / 128.0) * (2.0 ** (e - 127));
        return x[15] ? -m : m;
    endfunction

    function automatic bit is_nan_val(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
    endfunction

    function automatic bit beats(input logic [15:0] b, input logic [15:0] a);
        real rb = to_real(b);
        real ra = to_real(a);
        if (rb > ra) return 1'b1;
        return (rb == ra) && (rb == 0.0) && !b[15] && a[15];
    endfunction

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        case ($urandom_range(0, 15))
            0:       v = 16'h0000;
            1:       v = 16'h8000;
            2:       v = 16'hFF80;
            3:       v = 16'h7F80;
            4:       v = {1'($urandom_range(0, 1)), 8'hFF, 7'($urandom_range(1, 127))};
            5:       v = {1'b0, 8'h7F, 7'($urandom_range(0, 3))};
            default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 7'($urandom)};
        endcase
        return v;
    endfunction

    function automatic void row_reset();
        row_max = 16'hFF80;
        row_nan = 1'b0;
    endfunction

    function automatic void model_beat(input logic [VW-1:0] s, input logic [VW-1:0][15:0] v,
                                       input logic l);
        for (int i = 0; i < VW; i++) begin
            if (s[i]) begin
                if (is_nan_val(v[i])) row_nan = 1'b1;
                else if (beats(v[i], row_max)) row_max = v[i];
            end
        end
        if (l) begin
`ifdef SFM_MAX_NAN_PROPAGATE_EN
            exp_q.push_back(row_nan ? 16'h7FC0 : row_max);
`else
            exp_q.push_back(row_max);
`endif
            row_reset();
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) begin
            enable_i = ($urandom_range(0, 4) != 0);
            ready_i  = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic send_beat(input logic [VW-1:0] s, input logic [VW-1:0][15:0] v, input logic l);
        bit taken = 1'b0;
        valid_i = 1'b1;
        strb_i  = s;
        vect_i  = v;
        last_i  = l;
        for (int k = 0; k < 500 && !taken; k++) begin
            @(negedge clk);
            taken = ready_o;
            tick();
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
        check("beat accepted", 32'(taken), 32'd1);
        if (taken) model_beat(s, v, l);
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i && enable_i) begin
            if (exp_q.size() == 0) check("spurious result", 32'(max_o), 32'h1_0000);
            else check("row max", 32'(max_o), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        logic [VW-1:0][15:0] v;
        rst_n = 1'b0; clear_i = 1'b0; enable_i = 1'b1; valid_i = 1'b0; last_i = 1'b0;
        strb_i = '0; vect_i = '0; ready_i = 1'b1;
        row_reset();
        repeat (3) tick();
        check("reset valid_o", 32'(valid_o), 32'd0);
        check("reset max_o", 32'(max_o), 32'hFF80);
        rst_n = 1'b1;
        tick();
        check("idle ready_o", 32'(ready_o), 32'd1);

        // Single-beat row and its two-cycle latency.
        v = '0; v[0] = 16'h3F80; v[1] = 16'h4000; v[2] = 16'hC040;
        send_beat(16'h0007, v, 1'b1);
        check("t+1 valid_o", 32'(valid_o), 32'd0);
        check("t+1 ready_o", 32'(ready_o), 32'd0);
        tick();
        check("t+2 valid_o", 32'(valid_o), 32'd1);
        check("t+2 max_o", 32'(max_o), 32'h4000);
        tick();
        check("post handshake ready_o", 32'(ready_o), 32'd1);

        // Three beats, then downstream stall for five cycles in DONE.
        ready_i = 1'b0;
        v = '0; v[3] = 16'h3F80; send_beat(16'h0008, v, 1'b0);
        v = '0; v[5] = 16'h4040; v[6] = 16'hC100; send_beat(16'h0060, v, 1'b0);
        v = '0; v[0] = 16'h4000; send_beat(16'h0001, v, 1'b1);
        check("drain ready_o", 32'(ready_o), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("stall valid_o", 32'(valid_o), 32'd1);
            check("stall max_o", 32'(max_o), 32'h4040);
            check("stall ready_o", 32'(ready_o), 32'd0);
            tick();
        end
        ready_i = 1'b1;
        tick();
        check("restart ready_o", 32'(ready_o), 32'd1);

        // All lanes masked.
        v = '0; v[0] = 16'h7F00;
        send_beat(16'h0000, v, 1'b1);
        repeat (3) tick();

        // Signed zeros, then a NaN lane.
        v = '0; v[0] = 16'h8000; v[1] = 16'h0000;
        send_beat(16'h0003, v, 1'b1);
        repeat (3) tick();
        v = '0; v[0] = 16'h7FC0; v[1] = 16'h3F80; v[2] = 16'hBF80;
        send_beat(16'h0007, v, 1'b1);
        repeat (3) tick();

        // Clear mid-row while stalled; the partial maximum must vanish.
        v = '0; v[0] = 16'h4000;
        send_beat(16'h0001, v, 1'b0);
        clear_i = 1'b1; enable_i = 1'b0;
        tick();
        clear_i = 1'b0;
        check("clear valid_o", 32'(valid_o), 32'd0);
        check("clear max_o", 32'(max_o), 32'hFF80);
        check("clear stalled ready_o", 32'(ready_o), 32'd0);
        row_reset();
        enable_i = 1'b1;
        tick();
        check("clear ready_o", 32'(ready_o), 32'd1);
        v = '0; v[4] = 16'h3F80;
        send_beat(16'h0010, v, 1'b1);
        repeat (3) tick();

        // Reset mid-row: no result for the partial row.
        v = '0; v[1] = 16'h4200;
        send_beat(16'h0002, v, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid-row reset valid_o", 32'(valid_o), 32'd0);
        check("mid-row reset max_o", 32'(max_o), 32'hFF80);
        row_reset();
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized rows with random stalls and backpressure.
        rnd = 1'b1;
        for (int r = 0; r < 40; r++) begin
            int n = $urandom_range(1, 4);
            for (int b = 0; b < n; b++) begin
                for (int i = 0; i < VW; i++) v[i] = rand_val();
                send_beat(VW'($urandom) & VW'($urandom | $urandom), v, b == n - 1);
            end
        end
        rnd = 1'b0;
        enable_i = 1'b1;
        ready_i = 1'b1;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
